// File: rtl/psk_signal_formatter_pkg.sv
// psk_pkg
// Shared definitions for the PSK DAC-path blocks.
//   psk_mode_e    : 2-bit formatter mode encoding
//   is_bpsk_mode  : true for the two single-rail (BPSK) modes
package psk_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK_I   = 2'b00,
    MODE_BPSK_Q   = 2'b01,
    MODE_QPSK_AVG = 2'b10,
    MODE_MUTE     = 2'b11
  } psk_mode_e;

  function automatic logic is_bpsk_mode(input logic [1:0] mode);
    return (mode == MODE_BPSK_I) || (mode == MODE_BPSK_Q);
  endfunction

endpackage

// File: rtl/psk_signal_formatter_if.sv
// psk_signal_formatter_if
// Valid/ready sample bus around the PSK signal formatter.
//   in_valid/in_ready      : upstream handshake
//   in_i/in_q              : signed baseband samples (I_WIDTH)
//   in_mode/in_sym_start   : mode select, latched only on symbol starts
//   out_valid/out_ready    : downstream handshake
//   out_data/out_is_bpsk   : formatted DAC sample and its mode tag
// master = upstream/downstream environment, slave = formatter.
interface psk_signal_formatter_if #(
  parameter int I_WIDTH = 12,
  parameter int O_WIDTH = 16
);

  logic                      in_valid;
  logic                      in_ready;
  logic signed [I_WIDTH-1:0] in_i;
  logic signed [I_WIDTH-1:0] in_q;
  logic [1:0]                in_mode;
  logic                      in_sym_start;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [O_WIDTH-1:0] out_data;
  logic                      out_is_bpsk;

  modport master (
    output in_valid, in_i, in_q, in_mode, in_sym_start, out_ready,
    input  in_ready, out_valid, out_data, out_is_bpsk
  );

  modport slave (
    input  in_valid, in_i, in_q, in_mode, in_sym_start, out_ready,
    output in_ready, out_valid, out_data, out_is_bpsk
  );

endinterface

// File: rtl/psk_signal_formatter_sat_shift.sv
// psk_sat_shift
// Combinational left shift by SHIFT followed by saturation to OUT_W bits.
//   in_val  : signed input (IN_W)
//   out_val : shifted and clamped value (OUT_W)
//   sat     : high when clamping was applied
module psk_sat_shift #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 16,
  parameter int SHIFT = 4
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    sat
);

  // Wide enough that the shift itself can never lose bits, so the
  // range test below sees the true shifted value.
  localparam int EXT_W = ((IN_W > OUT_W) ? IN_W : OUT_W) + SHIFT + 1;

  localparam logic signed [EXT_W-1:0] MAX_POS =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_NEG =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] shifted;

  // Sign-extend, shift, then clamp to the output range.
  always_comb begin
    shifted = EXT_W'(in_val) <<< SHIFT;
    sat     = 1'b0;
    out_val = shifted[OUT_W-1:0];
    if (shifted > MAX_POS) begin
      out_val = {1'b0, {(OUT_W-1){1'b1}}};
      sat     = 1'b1;
    end else if (shifted < MIN_NEG) begin
      out_val = {1'b1, {(OUT_W-1){1'b0}}};
      sat     = 1'b1;
    end
  end

endmodule

// File: rtl/psk_signal_formatter.sv
// psk_signal_formatter
// Formats baseband I/Q into a single signed DAC sample stream.
// Two-stage valid/ready pipeline: S1 selects/combines I and Q, S2 applies
// the gain shift with saturation and drives the output registers.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : sample bus (slave modport), see psk_signal_formatter_if
//   sat_clr    : clears saturation statistics
//   sat_count  : number of saturated samples, sticks at all-ones
//   sat_flag   : sticky saturation indicator
module psk_signal_formatter
  import psk_pkg::*;
#(
  parameter int I_WIDTH       = 12,
  parameter int O_WIDTH       = 16,
  parameter int GAIN_SHIFT    = 4,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  psk_signal_formatter_if.slave    bus,
  input  logic                     sat_clr,
  output logic [SAT_CNT_WIDTH-1:0] sat_count,
  output logic                     sat_flag
);

  localparam int C_W = I_WIDTH + 1;

  logic                      en;
  logic                      accept;
  psk_mode_e                 active_mode;
  psk_mode_e                 mode_now;
  logic signed [I_WIDTH+1:0] qpsk_sum;
  logic signed [C_W-1:0]     c_next;

  logic                      s1_valid;
  logic signed [C_W-1:0]     s1_c;
  logic                      s1_bpsk;

  logic signed [O_WIDTH-1:0] sat_val;
  logic                      sat_hit;
  logic                      sat_evt;

  // The whole pipeline advances together whenever the output slot is free
  // or being drained; this makes in_ready combinational from out_ready.
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;
  assign accept       = bus.in_valid && en;

  // A symbol-start beat uses its own mode immediately rather than waiting
  // for the latch to update.
  always_comb begin
    mode_now = active_mode;
    if (accept && bus.in_sym_start) begin
      mode_now = psk_mode_e'(bus.in_mode);
    end
  end

  // Combine in I_WIDTH+2 bits so the +1 rounding term cannot overflow,
  // then drop the LSB for the halving.
  always_comb begin
    qpsk_sum = (I_WIDTH+2)'(bus.in_i) + (I_WIDTH+2)'(bus.in_q)
             + (I_WIDTH+2)'(1);
    case (mode_now)
      MODE_BPSK_I:   c_next = C_W'(bus.in_i);
      MODE_BPSK_Q:   c_next = C_W'(bus.in_q);
      MODE_QPSK_AVG: c_next = qpsk_sum[I_WIDTH+1:1];
      default:       c_next = '0;
    endcase
  end

  // Stage 1: mode latch and combined sample register.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_mode <= MODE_BPSK_I;
      s1_valid    <= 1'b0;
      s1_c        <= '0;
      s1_bpsk     <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      if (accept) begin
        s1_c    <= c_next;
        s1_bpsk <= is_bpsk_mode(mode_now);
        if (bus.in_sym_start) begin
          active_mode <= psk_mode_e'(bus.in_mode);
        end
      end
    end
  end

  psk_sat_shift #(
    .IN_W  (C_W),
    .OUT_W (O_WIDTH),
    .SHIFT (GAIN_SHIFT)
  ) u_sat_shift (
    .in_val  (s1_c),
    .out_val (sat_val),
    .sat     (sat_hit)
  );

  assign sat_evt = en && s1_valid && sat_hit;

  // Stage 2: scaled/saturated output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_is_bpsk <= 1'b0;
    end else if (en) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data    <= sat_val;
        bus.out_is_bpsk <= s1_bpsk;
      end
    end
  end

  // Saturation statistics; an event in the clearing cycle survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
      sat_flag  <= 1'b0;
    end else if (sat_clr) begin
      sat_count <= sat_evt ? SAT_CNT_WIDTH'(1) : '0;
      sat_flag  <= sat_evt;
    end else if (sat_evt) begin
      sat_flag <= 1'b1;
      if (sat_count != '1) begin
        sat_count <= sat_count + SAT_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_psk_signal_formatter.sv
// tb_psk_signal_formatter
// Directed bench for psk_signal_formatter. Two instances share the clock:
//   dut4 : I=12, O=16, GAIN_SHIFT=4, SAT_CNT_WIDTH=16
//   dut5 : I=12, O=16, GAIN_SHIFT=5, SAT_CNT_WIDTH=2 (small counter to
//          reach the sticking point quickly)
module tb_psk_signal_formatter;

  logic       clk = 1'b0;
  logic       rst4, rst5, sat_clr4, sat_clr5;
  logic [15:0] sat_count4;
  logic [1:0]  sat_count5;
  logic       sat_flag4, sat_flag5;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  psk_signal_formatter_if #(.I_WIDTH(12), .O_WIDTH(16)) bus4 ();
  psk_signal_formatter_if #(.I_WIDTH(12), .O_WIDTH(16)) bus5 ();

  psk_signal_formatter #(.I_WIDTH(12), .O_WIDTH(16), .GAIN_SHIFT(4), .SAT_CNT_WIDTH(16)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4.slave),
    .sat_clr(sat_clr4), .sat_count(sat_count4), .sat_flag(sat_flag4));

  psk_signal_formatter #(.I_WIDTH(12), .O_WIDTH(16), .GAIN_SHIFT(5), .SAT_CNT_WIDTH(2)) dut5 (
    .clk(clk), .rst(rst5), .bus(bus5.slave),
    .sat_clr(sat_clr5), .sat_count(sat_count5), .sat_flag(sat_flag5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input int i, input int q, input logic [1:0] mode, input logic sym);
    bus4.in_valid = 1'b1; bus4.in_i = 12'(i); bus4.in_q = 12'(q);
    bus4.in_mode = mode; bus4.in_sym_start = sym;
  endtask

  task automatic drive5(input int i, input int q, input logic [1:0] mode, input logic sym);
    bus5.in_valid = 1'b1; bus5.in_i = 12'(i); bus5.in_q = 12'(q);
    bus5.in_mode = mode; bus5.in_sym_start = sym;
  endtask

  task automatic idle4();
    bus4.in_valid = 1'b0; bus4.in_sym_start = 1'b0;
  endtask

  task automatic idle5();
    bus5.in_valid = 1'b0; bus5.in_sym_start = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    idle4(); idle5();
    bus4.in_i = '0; bus4.in_q = '0; bus4.in_mode = 2'b00; bus4.out_ready = 1'b0;
    bus5.in_i = '0; bus5.in_q = '0; bus5.in_mode = 2'b00; bus5.out_ready = 1'b0;
    sat_clr4 = 1'b0; sat_clr5 = 1'b0;
    rst4 = 1'b1; rst5 = 1'b1;
    tick(); tick();
    rst4 = 1'b0; rst5 = 1'b0;
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus4.out_valid); end
    checks++; if (bus4.out_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=0000", bus4.out_data); end
    checks++; if (bus4.out_is_bpsk !== 1'b0) begin failures++; $display("[TB] FAIL reset_is_bpsk got=%b exp=0", bus4.out_is_bpsk); end
    checks++; if (sat_count4 !== 16'd0 || sat_flag4 !== 1'b0) begin failures++; $display("[TB] FAIL reset_sat got=%0d/%b exp=0/0", sat_count4, sat_flag4); end
    checks++; if (bus4.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus4.in_ready); end
    checks++; if (bus5.out_valid !== 1'b0 || sat_count5 !== 2'd0) begin failures++; $display("[TB] FAIL reset_dut5 got=%b/%0d exp=0/0", bus5.out_valid, sat_count5); end
    bus4.out_ready = 1'b1; bus5.out_ready = 1'b1;
  endtask

  task automatic test_bpsk_i();
    $display("[TB] test_bpsk_i");
    drive4(2047, 0, 2'b00, 1'b1);
    tick();
    idle4();
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bpsk_latency got=%b exp=0", bus4.out_valid); end
    tick();
    checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'h7FF0 || bus4.out_is_bpsk !== 1'b1)
      begin failures++; $display("[TB] FAIL bpsk_max got=%b/%h/%b exp=1/7ff0/1", bus4.out_valid, bus4.out_data, bus4.out_is_bpsk); end
    drive4(-2048, 0, 2'b00, 1'b0);
    tick();
    idle4();
    tick();
    checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'h8000 || bus4.out_is_bpsk !== 1'b1)
      begin failures++; $display("[TB] FAIL bpsk_min got=%b/%h/%b exp=1/8000/1", bus4.out_valid, bus4.out_data, bus4.out_is_bpsk); end
    checks++; if (sat_count4 !== 16'd0 || sat_flag4 !== 1'b0) begin failures++; $display("[TB] FAIL bpsk_no_sat got=%0d/%b exp=0/0", sat_count4, sat_flag4); end
    tick();
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bpsk_bubble got=%b exp=0", bus4.out_valid); end
  endtask

  task automatic test_qpsk();
    int qi[4] = '{2047, 1, -1, -2048};
    int qq[4] = '{2047, 0, 0, -2048};
    logic [15:0] qexp[4] = '{16'h7FF0, 16'h0010, 16'h0000, 16'h8000};
    $display("[TB] test_qpsk");
    for (int k = 0; k < 4; k++) begin
      drive4(qi[k], qq[k], 2'b10, (k == 0));
      tick();
      idle4();
      tick();
      checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== qexp[k] || bus4.out_is_bpsk !== 1'b0)
        begin failures++; $display("[TB] FAIL qpsk_%0d got=%b/%h/%b exp=1/%h/0", k, bus4.out_valid, bus4.out_data, bus4.out_is_bpsk, qexp[k]); end
    end
  endtask

  task automatic test_mode_latch();
    logic [1:0]  modes[5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b11};
    logic        syms[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          vi[5]    = '{10, 10, 10, 10, 100};
    int          vq[5]    = '{20, 20, 20, 20, 100};
    logic [15:0] ve[5]    = '{16'h0140, 16'h0140, 16'h00F0, 16'h00F0, 16'h0000};
    logic        vb[5]    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    $display("[TB] test_mode_latch");
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) drive4(vi[k], vq[k], modes[k], syms[k]);
      else idle4();
      tick();
      if (k > 0) begin
        checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== ve[k-1] || bus4.out_is_bpsk !== vb[k-1])
          begin failures++; $display("[TB] FAIL mode_beat_%0d got=%b/%h/%b exp=1/%h/%b", k-1, bus4.out_valid, bus4.out_data, bus4.out_is_bpsk, ve[k-1], vb[k-1]); end
      end
    end
    tick();
  endtask

  task automatic test_back_to_back_stall();
    int          vi[8] = '{1, -1, 100, -100, 2047, -2048, 5, 0};
    logic [15:0] ve[8] = '{16'h0010, 16'hFFF0, 16'h0640, 16'hF9C0, 16'h7FF0, 16'h8000, 16'h0050, 16'h0000};
    logic [15:0] exp_q[$];
    logic [15:0] held = '0;
    logic [15:0] want;
    int sent = 0;
    int recv = 0;
    $display("[TB] test_back_to_back_stall");
    for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
      bus4.out_ready = !(cyc >= 4 && cyc <= 6);
      if (sent < 8) drive4(vi[sent], 0, 2'b00, (sent == 0));
      else idle4();
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        checks++; if (bus4.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, bus4.in_ready); end
        if (cyc == 4) held = bus4.out_data;
        else begin
          checks++; if (bus4.out_data !== held) begin failures++; $display("[TB] FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, bus4.out_data, held); end
        end
      end
      if (bus4.in_valid && bus4.in_ready) begin
        exp_q.push_back(ve[sent]);
        sent++;
      end
      if (bus4.out_valid && bus4.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("[TB] FAIL stream_extra got=%h exp=none", bus4.out_data);
        end else begin
          want = exp_q.pop_front();
          if (bus4.out_data !== want) begin failures++; $display("[TB] FAIL stream_%0d got=%h exp=%h", recv, bus4.out_data, want); end
        end
        recv++;
      end
      tick();
    end
    idle4();
    bus4.out_ready = 1'b1;
    checks++; if (recv != 8 || sent != 8) begin failures++; $display("[TB] FAIL stream_count got=%0d/%0d exp=8/8", sent, recv); end
    tick();
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL stream_dup got=%b exp=0", bus4.out_valid); end
  endtask

  task automatic test_saturation();
    $display("[TB] test_saturation");
    drive5(2047, 0, 2'b00, 1'b1);
    tick();
    idle5();
    tick();
    checks++; if (bus5.out_data !== 16'h7FFF || sat_count5 !== 2'd1 || sat_flag5 !== 1'b1)
      begin failures++; $display("[TB] FAIL sat_pos got=%h/%0d/%b exp=7fff/1/1", bus5.out_data, sat_count5, sat_flag5); end
    drive5(-2048, 0, 2'b00, 1'b0);
    tick();
    idle5();
    sat_clr5 = 1'b1;
    tick();
    sat_clr5 = 1'b0;
    checks++; if (bus5.out_data !== 16'h8000 || sat_count5 !== 2'd1 || sat_flag5 !== 1'b1)
      begin failures++; $display("[TB] FAIL sat_clr_evt got=%h/%0d/%b exp=8000/1/1", bus5.out_data, sat_count5, sat_flag5); end
    sat_clr5 = 1'b1;
    tick();
    sat_clr5 = 1'b0;
    checks++; if (sat_count5 !== 2'd0 || sat_flag5 !== 1'b0) begin failures++; $display("[TB] FAIL sat_clr got=%0d/%b exp=0/0", sat_count5, sat_flag5); end
    drive5(1, 0, 2'b00, 1'b0);
    tick();
    idle5();
    tick();
    checks++; if (bus5.out_data !== 16'h0020 || sat_count5 !== 2'd0 || sat_flag5 !== 1'b0)
      begin failures++; $display("[TB] FAIL sat_none got=%h/%0d/%b exp=0020/0/0", bus5.out_data, sat_count5, sat_flag5); end
    for (int k = 0; k < 4; k++) begin
      drive5(-2048, 0, 2'b00, 1'b0);
      tick();
    end
    idle5();
    tick();
    checks++; if (bus5.out_data !== 16'h8000 || sat_count5 !== 2'd3 || sat_flag5 !== 1'b1)
      begin failures++; $display("[TB] FAIL sat_stick got=%h/%0d/%b exp=8000/3/1", bus5.out_data, sat_count5, sat_flag5); end
    rst5 = 1'b1;
    tick();
    rst5 = 1'b0;
    checks++; if (sat_count5 !== 2'd0 || sat_flag5 !== 1'b0 || bus5.out_valid !== 1'b0)
      begin failures++; $display("[TB] FAIL sat_reset got=%0d/%b/%b exp=0/0/0", sat_count5, sat_flag5, bus5.out_valid); end
  endtask

  task automatic test_reset_midstream();
    $display("[TB] test_reset_midstream");
    bus4.out_ready = 1'b1;
    drive4(40, 60, 2'b10, 1'b1);
    tick();
    drive4(40, 60, 2'b10, 1'b0);
    tick();
    idle4();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 16'h0000 || sat_count4 !== 16'd0)
      begin failures++; $display("[TB] FAIL midrst_state got=%b/%h/%0d exp=0/0000/0", bus4.out_valid, bus4.out_data, sat_count4); end
    bus4.out_ready = 1'b0;
    #1;
    checks++; if (bus4.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_in_ready got=%b exp=1", bus4.in_ready); end
    bus4.out_ready = 1'b1;
    tick();
    checks++; if (bus4.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_flush got=%b exp=0", bus4.out_valid); end
    drive4(3, 50, 2'b10, 1'b0);
    tick();
    idle4();
    tick();
    checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'h0030 || bus4.out_is_bpsk !== 1'b1)
      begin failures++; $display("[TB] FAIL midrst_mode got=%b/%h/%b exp=1/0030/1", bus4.out_valid, bus4.out_data, bus4.out_is_bpsk); end
  endtask

  initial begin
    test_reset();
    test_bpsk_i();
    test_qpsk();
    test_mode_latch();
    test_back_to_back_stall();
    test_saturation();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
